// File: rtl/arm7_pkg.sv
// rtl/arm7_pkg.sv - shared widths, fetch FSM states and address helpers for the fetch stage
package arm7_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] WORD_INC = 32'd4;

  typedef enum logic [1:0] {
    F_IDLE,
    F_WAIT,
    F_DROP
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue storage: synchronous FIFO whose flush overrides push and pop
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end
endmodule

// File: rtl/arm7_fetch_unit.sv
// rtl/arm7_fetch_unit.sv - instruction fetch stage: request FSM, fetch PC and prefetch queue
module arm7_fetch_unit import arm7_pkg::*; #(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc4,
  input  logic               if_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e              state_q;
  logic [ADDR_W-1:0]         fetch_pc_q, req_addr_q, pc_plus4;
  logic                      run_q, can_req;
  logic                      fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0]             fifo_count;
  logic [INSTR_W+ADDR_W-1:0] fifo_rdata;

  assign pc_plus4 = fetch_pc_q + WORD_INC;
  // run_q keeps the bus quiet during reset and for the first cycle after release.
  assign can_req  = run_q && (fifo_count < CW'(DEPTH));

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc_q;
    case (state_q)
      F_IDLE: imem_req = can_req && !br_taken;
      F_WAIT, F_DROP: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
      end
      default: imem_req = 1'b0;
    endcase
  end

  // A response is kept only for a live request with no branch in the same cycle.
  assign fifo_push = imem_ack && !br_taken && !fifo_full &&
                     ((state_q == F_IDLE && imem_req) || state_q == F_WAIT);
  assign fifo_pop  = if_valid && if_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= F_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      run_q      <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (br_taken)       fetch_pc_q <= word_align(br_target);
      else if (fifo_push) fetch_pc_q <= pc_plus4;
      case (state_q)
        F_IDLE: begin
          if (imem_req && !imem_ack) begin
            state_q    <= F_WAIT;
            req_addr_q <= fetch_pc_q;
          end
        end
        F_WAIT: begin
          if (imem_ack)      state_q <= F_IDLE;
          else if (br_taken) state_q <= F_DROP;
        end
        F_DROP: begin
          if (imem_ack) state_q <= F_IDLE;
        end
        default: state_q <= F_IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W + ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (br_taken),
    .wdata_i ({imem_rdata, pc_plus4}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign if_valid = !fifo_empty;
  assign if_instr = fifo_empty ? '0 : fifo_rdata[INSTR_W+ADDR_W-1:ADDR_W];
  assign if_pc4   = fifo_empty ? '0 : fifo_rdata[ADDR_W-1:0];
endmodule

// File: tb/tb_arm7_fetch_unit.sv
// tb/tb_arm7_fetch_unit.sv - self-checking bench: program-order model plus directed and random fetch scenarios
module tb_arm7_fetch_unit;
  logic        clk, rst, br_taken, imem_req, imem_ack, if_valid, if_ready;
  logic [31:0] br_target, imem_addr, imem_rdata, if_instr, if_pc4;

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          wait_cnt = 0;
  int          acks = 0;
  int          pops = 0;
  int          n, vcnt, a0, p0;
  logic        hold_valid = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [31:0] exp_pc = '0;
  logic [31:0] stale;

  arm7_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc4     (if_pc4),
    .if_ready   (if_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // One clock: memory answers after lat cycles of request, decode stream is checked
  // against program order (consecutive words, restarting at each branch target).
  task automatic tick();
    #1;
    if (imem_req) begin
      if (hold_valid) chk("addr_hold", imem_addr, hold_addr);
      imem_ack   = (wait_cnt >= lat - 1);
      imem_rdata = imem_ack ? mem_word(imem_addr) : 32'h0;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
    end
    if (if_valid && if_ready && !br_taken) begin
      chk("pop_pc4", if_pc4, exp_pc + 32'd4);
      chk("pop_instr", if_instr, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (br_taken) exp_pc = br_target & ~32'h3;
    if (imem_req && !imem_ack) begin
      hold_valid = 1'b1;
      hold_addr  = imem_addr;
      wait_cnt++;
    end else begin
      hold_valid = 1'b0;
      wait_cnt   = 0;
    end
    if (imem_ack) acks++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; br_taken = 1'b0; br_target = '0; if_ready = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", if_valid, 1'b0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc4", if_pc4, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // 0-wait memory: one request and one instruction per cycle
    lat = 1;
    n = 0;
    while (!imem_req && n < 10) begin tick(); n++; end
    chk1("t1_req_start", imem_req, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk1("t1_req", imem_req, 1'b1);
      chk("t1_addr", imem_addr, 32'(4 * k));
      if (k > 0) begin
        chk1("t1_valid", if_valid, 1'b1);
        chk("t1_pc4", if_pc4, 32'(4 * k));
      end
      tick();
    end

    // 3-cycle memory: one word every third cycle
    lat = 3;
    repeat (6) tick();
    vcnt = 0; a0 = acks;
    for (int k = 0; k < 12; k++) begin
      if (if_valid) vcnt++;
      tick();
    end
    chk("t2_valid_cycles", 32'(vcnt), 32'd4);
    chk("t2_acks", 32'(acks - a0), 32'd4);

    // decode stall fills the queue, then drains exactly DEPTH words
    lat = 1; if_ready = 1'b0;
    repeat (10) tick();
    chk1("t3_req_full", imem_req, 1'b0);
    chk1("t3_valid_full", if_valid, 1'b1);
    lat = 100; if_ready = 1'b1; p0 = pops;
    repeat (8) tick();
    chk("t3_drained", 32'(pops - p0), 32'd4);
    lat = 1;

    // branch while a request waits: late data dropped, fetch resumes at 0x100
    lat = 4;
    n = 0;
    while (!(imem_req && !hold_valid) && n < 20) begin tick(); n++; end
    tick();
    chk1("t4_req_wait", imem_req, 1'b1);
    stale = imem_addr;
    br_taken = 1'b1; br_target = 32'h103;
    tick();
    br_taken = 1'b0;
    chk1("t4_drop_req", imem_req, 1'b1);
    chk("t4_drop_addr", imem_addr, stale);
    chk1("t4_flushed", if_valid, 1'b0);
    n = 0;
    while (!(imem_req && imem_addr == 32'h100) && n < 20) begin tick(); n++; end
    chk("t4_redirect", imem_addr, 32'h100);
    n = 0;
    while (!if_valid && n < 20) begin tick(); n++; end
    chk("t4_instr", if_instr, mem_word(32'h100));
    chk("t4_pc4", if_pc4, 32'h104);

    // branch, ack and pop together with a non-empty queue
    lat = 2; if_ready = 1'b0;
    n = 0;
    while (!(hold_valid && if_valid) && n < 20) begin tick(); n++; end
    chk1("t5_setup", if_valid, 1'b1);
    if_ready = 1'b1; br_taken = 1'b1; br_target = 32'h2000; a0 = acks;
    tick();
    br_taken = 1'b0;
    chk("t5_ack_taken", 32'(acks - a0), 32'd1);
    chk1("t5_empty", if_valid, 1'b0);
    n = 0;
    while (!if_valid && n < 20) begin tick(); n++; end
    chk("t5_instr", if_instr, mem_word(32'h2000));
    chk("t5_pc4", if_pc4, 32'h2004);

    // address wrap at the top of memory
    lat = 1; br_taken = 1'b1; br_target = 32'hFFFF_FFFE;
    tick();
    br_taken = 1'b0;
    chk("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_wrap_addr", imem_addr, 32'h0);
    chk1("t6_wrap_valid", if_valid, 1'b1);
    chk("t6_wrap_pc4", if_pc4, 32'h0);
    chk("t6_wrap_instr", if_instr, mem_word(32'hFFFF_FFFC));

    // asynchronous reset in the middle of a waiting request
    if_ready = 1'b0; lat = 6;
    n = 0;
    while (!(hold_valid && if_valid) && n < 20) begin tick(); n++; end
    chk1("t6_pre_valid", if_valid, 1'b1);
    chk1("t6_pre_req", imem_req, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk1("t6_rst_req", imem_req, 1'b0);
    chk1("t6_rst_valid", if_valid, 1'b0);
    chk("t6_rst_instr", if_instr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = '0;
    rst = 1'b1; if_ready = 1'b1;
    exp_pc = 32'h0; hold_valid = 1'b0; wait_cnt = 0; lat = 1;
    #1;
    chk1("t6_post_valid", if_valid, 1'b0);
    chk("t6_post_addr", imem_addr, 32'h0);
    @(negedge clk);

    // random latency, stalls and branches against the program-order model
    p0 = pops;
    for (int i = 0; i < 400; i++) begin
      if (!hold_valid) lat = $urandom_range(1, 4);
      if_ready  = ($urandom_range(0, 9) < 7);
      br_taken  = ($urandom_range(0, 19) == 0);
      br_target = $urandom;
      tick();
    end
    br_taken = 1'b0;
    chk1("rand_progress", (pops - p0) > 20, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end
endmodule
